// File: rtl/pcie_msg_transmitter.sv
// pcie_msg_transmitter: SRAM message to AXI4 header+payload fragment bursts; optional PCIE_MSG_TX_BAD_VER_INJ_EN adds inj_bad_ver
module pcie_msg_transmitter #(
  parameter int MAX_FRAG_BEATS = 8,
  parameter logic [3:0] HDR_VERSION = 4'h1,
  parameter logic [63:0] DEST_ADDR = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PCIE_MSG_TX_BAD_VER_INJ_EN
  input  logic         inj_bad_ver,
`endif
  input  logic         start,
  input  logic [9:0]   msg_sram_addr,
  input  logic [11:0]  msg_beats,
  input  logic [3:0]   msg_tag,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [7:0]   frag_sent,
  output logic [63:0]  axi_awaddr,
  output logic [7:0]   axi_awlen,
  output logic [2:0]   axi_awsize,
  output logic [1:0]   axi_awburst,
  output logic         axi_awvalid,
  input  logic         axi_awready,
  output logic [255:0] axi_wdata,
  output logic [31:0]  axi_wstrb,
  output logic         axi_wlast,
  output logic         axi_wvalid,
  input  logic         axi_wready,
  input  logic [1:0]   axi_bresp,
  input  logic         axi_bvalid,
  output logic         axi_bready,
  output logic         sram_ren,
  output logic [9:0]   sram_raddr,
  input  logic [255:0] sram_rdata
);
  typedef enum logic [2:0] {IDLE, AW, HDR, DATA, RESP, DONE} state_t;
  state_t state;
  logic [11:0] total, rem, rem_next;
  logic [3:0] tag;
  logic [7:0] reads_left, wleft, cur;
  logic [1:0] seq, cnt;
  logic som, eom, fail, inflight, rd_ptr, wr_ptr, bad, pop, push;
  logic [255:0] buffer [2];
  logic [127:0] hdr;
  function automatic logic [7:0] frag_of(input logic [11:0] r);
    return (r > 12'(MAX_FRAG_BEATS)) ? 8'(MAX_FRAG_BEATS) : r[7:0];
  endfunction
  assign cur = frag_of(rem);
  assign eom = rem <= 12'(MAX_FRAG_BEATS);
  assign rem_next = rem - {4'b0, cur};
  assign hdr = {96'b0, total, cur, seq, eom, som, tag, HDR_VERSION ^ {4{bad}}};
  assign axi_awaddr = DEST_ADDR;
  assign axi_awsize = 3'd5;
  assign axi_awburst = 2'b01;
  assign axi_wstrb = '1;
  assign axi_awlen = cur;
  assign axi_awvalid = state == AW;
  assign axi_bready = state == RESP;
  assign axi_wvalid = state == HDR || (state == DATA && cnt != 2'd0);
  assign axi_wlast = state == DATA && cnt != 2'd0 && wleft == 8'd1;
  assign axi_wdata = state == HDR ? {128'b0, hdr} : state == DATA ? buffer[rd_ptr] : '0;
  assign pop = state == DATA && axi_wvalid && axi_wready;
  assign push = inflight;
  // occupancy counts the beat leaving this cycle so a ready sink sees no bubbles
  assign sram_ren = (state == AW || state == HDR || state == DATA) && reads_left != 8'd0 &&
                    ({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
`ifndef PCIE_MSG_TX_BAD_VER_INJ_EN
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {total, rem, tag, reads_left, wleft, seq, cnt} <= '0;
      {som, fail, inflight, rd_ptr, wr_ptr, busy, done, err} <= '0;
      frag_sent <= '0;
      sram_raddr <= '0;
`ifdef PCIE_MSG_TX_BAD_VER_INJ_EN
      bad <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      inflight <= sram_ren;
      if (sram_ren) begin
        sram_raddr <= sram_raddr + 10'd1;
        reads_left <= reads_left - 8'd1;
      end
      if (push) begin
        buffer[wr_ptr] <= sram_rdata;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
      case (state)
        IDLE: if (start) begin
          frag_sent <= '0;
          fail <= msg_beats == 12'd0;
          state <= msg_beats == 12'd0 ? DONE : AW;
          busy <= msg_beats != 12'd0;
          total <= msg_beats;
          rem <= msg_beats;
          tag <= msg_tag;
          sram_raddr <= msg_sram_addr;
          reads_left <= frag_of(msg_beats);
          seq <= '0;
          som <= 1'b1;
`ifdef PCIE_MSG_TX_BAD_VER_INJ_EN
          bad <= inj_bad_ver;
`endif
        end
        AW: if (axi_awready) begin
          state <= HDR;
          wleft <= cur;
        end
        HDR: if (axi_wready) state <= DATA;
        DATA: if (pop) begin
          wleft <= wleft - 8'd1;
          if (wleft == 8'd1) state <= RESP;
        end
        RESP: if (axi_bvalid) begin
          if (axi_bresp == 2'b00) begin
            frag_sent <= frag_sent + 8'd1;
            seq <= seq + 2'd1;
            som <= 1'b0;
            rem <= rem_next;
            reads_left <= frag_of(rem_next);
            state <= eom ? DONE : AW;
          end else begin
            fail <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          err <= fail;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_msg_transmitter.sv
// tb_pcie_msg_transmitter: directed vectors against hand-computed fragment streams for pcie_msg_transmitter
module tb_pcie_msg_transmitter;
  logic clk = 0, rst = 1, start = 0, inj = 0;
  logic [9:0] addr_in = '0;
  logic [11:0] beats_in = '0;
  logic [3:0] tag_in = '0;
  logic busy, done, err, axi_awvalid, axi_wlast, axi_wvalid, axi_bready, sram_ren;
  logic [7:0] frag_sent, axi_awlen;
  logic [63:0] axi_awaddr;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst, axi_bresp;
  logic [255:0] axi_wdata, sram_rdata;
  logic [31:0] axi_wstrb;
  logic [9:0] sram_raddr;
  logic awready = 1, wready = 1, bvalid = 1;
  int checks = 0, failures = 0, b_cnt = 0, bad_b = 0;
  int aw_seen = 0, ren_seen = 0, done_cnt = 0, stall_bad = 0, stall_n = 0;
  bit toggle = 0;
  logic [255:0] w_q[$];
  logic wl_q[$];
  logic [7:0] aw_q[$];
  logic [9:0] rd_q[$];
  logic hold_v = 0;
  logic [255:0] hold_d = '0;

  pcie_msg_transmitter dut (
`ifdef PCIE_MSG_TX_BAD_VER_INJ_EN
    .inj_bad_ver(inj),
`endif
    .clk(clk), .rst(rst), .start(start), .msg_sram_addr(addr_in), .msg_beats(beats_in),
    .msg_tag(tag_in), .busy(busy), .done(done), .err(err), .frag_sent(frag_sent),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(wready), .axi_bresp(axi_bresp),
    .axi_bvalid(bvalid), .axi_bready(axi_bready), .sram_ren(sram_ren),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] word(input logic [9:0] a);
    return {8{{22'h3C0F0F, a}}};
  endfunction

  function automatic logic [31:0] hdr_of(input logic [3:0] t, input int total, input int n,
                                         input int seq, input bit som, input bit eom, input logic [3:0] ver);
    return {12'(total), 8'(n), 2'(seq), eom, som, t, ver};
  endfunction

  function automatic logic [255:0] getw(input int i);
    return (i < w_q.size()) ? w_q[i] : '1;
  endfunction

  function automatic logic getl(input int i);
    return (i < wl_q.size()) ? wl_q[i] : 1'b0;
  endfunction

  assign axi_bresp = (bad_b != 0 && b_cnt + 1 == bad_b) ? 2'b10 : 2'b00;
  always @(posedge clk) if (bvalid && axi_bready) b_cnt <= b_cnt + 1;
  always @(posedge clk) if (sram_ren) sram_rdata <= word(sram_raddr);

  always @(negedge clk) begin
    if (axi_awvalid && awready) begin aw_q.push_back(axi_awlen); aw_seen++; end
    if (axi_wvalid && wready) begin w_q.push_back(axi_wdata); wl_q.push_back(axi_wlast); end
    if (sram_ren) begin rd_q.push_back(sram_raddr); ren_seen++; end
    if (done) done_cnt++;
    if (hold_v && !(axi_wvalid && axi_wdata == hold_d)) stall_bad++;
    hold_v = axi_wvalid && !wready;
    hold_d = axi_wdata;
    if (hold_v) stall_n++;
  end

  initial forever begin
    @(posedge clk); #1;
    wready = toggle ? ~wready : 1'b1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [9:0] a, input logic [11:0] b, input logic [3:0] t);
    @(posedge clk); #1;
    addr_in = a; beats_in = b; tag_in = t; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag, output logic e, output logic [7:0] fs);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 4000);
    chk({tag, "_done"}, 256'(done), 256'(1));
    e = err;
    fs = frag_sent;
  endtask

  task automatic check_stream(input string tag, input int wb, input int ab, input logic [9:0] a,
                              input int beats, input logic [3:0] t, input int nf, input logic [3:0] ver);
    int idx = wb, rem = beats, n;
    logic [9:0] p = a;
    for (int f = 0; f < nf; f++) begin
      n = rem > 8 ? 8 : rem;
      chk({tag, "_awlen"}, 256'((ab + f < aw_q.size()) ? aw_q[ab + f] : 8'hFF), 256'(n));
      chk({tag, "_hdr"}, getw(idx), {224'b0, hdr_of(t, beats, n, f % 4, f == 0, rem <= 8, ver)});
      chk({tag, "_hdr_last"}, 256'(getl(idx)), 256'(0));
      idx++;
      for (int k = 0; k < n; k++) begin
        chk({tag, "_data"}, getw(idx), word(p));
        chk({tag, "_last"}, 256'(getl(idx)), 256'(k == n - 1));
        p++;
        idx++;
      end
      rem -= n;
    end
    chk({tag, "_nbeats"}, 256'(w_q.size() - wb), 256'(idx - wb));
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ctl"}, 256'({busy, done, err, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, sram_ren}), 256'(0));
    chk({tag, "_frag"}, 256'(frag_sent), 256'(0));
    chk({tag, "_raddr"}, 256'(sram_raddr), 256'(0));
    chk({tag, "_awlen"}, 256'(axi_awlen), 256'(0));
    chk({tag, "_wdata"}, axi_wdata, 256'(0));
    chk({tag, "_const"}, 256'({axi_awaddr, axi_awsize, axi_awburst, axi_wstrb}),
        256'({64'h0, 3'd5, 2'b01, 32'hFFFF_FFFF}));
  endtask

  initial begin
    logic e;
    logic [7:0] fs;
    logic [255:0] tmp;
    int wb, ab, rb, a0, r0, d0, s0, n0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_check("reset");
    rst = 0;

    wb = w_q.size(); ab = aw_q.size();
    go(10'h010, 12'd3, 4'hA);
    wait_done("t1", e, fs);
    chk("t1_err", 256'(e), 256'(0));
    chk("t1_frag", 256'(fs), 256'(1));
    tmp = getw(wb);
    chk("t1_hdr_lit", 256'(tmp[31:0]), 256'(32'h0030_33A1));
    check_stream("t1", wb, ab, 10'h010, 3, 4'hA, 1, 4'h1);

    wb = w_q.size(); ab = aw_q.size(); a0 = aw_seen;
    go(10'h100, 12'd20, 4'h5);
    wait_done("t2", e, fs);
    chk("t2_err", 256'(e), 256'(0));
    chk("t2_frag", 256'(fs), 256'(3));
    chk("t2_naw", 256'(aw_seen - a0), 256'(3));
    tmp = getw(wb);
    chk("t2_hdr0_lit", 256'(tmp[31:0]), 256'(32'h0140_8151));
    tmp = getw(wb + 18);
    chk("t2_hdr2_lit", 256'(tmp[31:0]), 256'(32'h0140_4A51));
    check_stream("t2", wb, ab, 10'h100, 20, 4'h5, 3, 4'h1);

    wb = w_q.size(); ab = aw_q.size(); s0 = stall_bad; n0 = stall_n;
    toggle = 1;
    go(10'h100, 12'd20, 4'h5);
    wait_done("t3", e, fs);
    toggle = 0;
    chk("t3_err", 256'(e), 256'(0));
    chk("t3_frag", 256'(fs), 256'(3));
    chk("t3_w_stable", 256'(stall_bad - s0), 256'(0));
    chk("t3_stalls_seen", 256'(stall_n > n0), 256'(1));
    check_stream("t3", wb, ab, 10'h100, 20, 4'h5, 3, 4'h1);

    wb = w_q.size(); ab = aw_q.size(); a0 = aw_seen;
    bad_b = b_cnt + 2;
    go(10'h200, 12'd20, 4'h7);
    wait_done("t4", e, fs);
    bad_b = 0;
    chk("t4_err", 256'(e), 256'(1));
    chk("t4_frag", 256'(fs), 256'(1));
    repeat (5) @(negedge clk);
    chk("t4_naw", 256'(aw_seen - a0), 256'(2));
    check_stream("t4", wb, ab, 10'h200, 20, 4'h7, 2, 4'h1);

    a0 = aw_seen; r0 = ren_seen;
    @(posedge clk); #1;
    beats_in = 12'd0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("t5_done_early", 256'({done, err}), 256'(0));
    @(negedge clk);
    chk("t5_done_err", 256'({done, err, busy}), 256'(3'b110));
    repeat (3) @(negedge clk);
    chk("t5_no_aw", 256'(aw_seen - a0), 256'(0));
    chk("t5_no_ren", 256'(ren_seen - r0), 256'(0));

    wb = w_q.size(); ab = aw_q.size(); rb = rd_q.size();
    go(10'h3FE, 12'd4, 4'h3);
    wait_done("t6", e, fs);
    chk("t6_err", 256'(e), 256'(0));
    chk("t6_nreads", 256'(rd_q.size() - rb), 256'(4));
    for (int i = 0; i < 4; i++)
      chk("t6_raddr", 256'((rb + i < rd_q.size()) ? rd_q[rb + i] : 10'h155), 256'(10'(10'h3FE + i)));
    check_stream("t6", wb, ab, 10'h3FE, 4, 4'h3, 1, 4'h1);

    wb = w_q.size();
    go(10'h040, 12'd20, 4'h6);
    n = 0;
    while (w_q.size() - wb < 12 && n < 500) begin @(negedge clk); n++; end
    chk("t7_reach_data", 256'(w_q.size() - wb >= 12), 256'(1));
    chk("t7_frag_before", 256'(frag_sent), 256'(1));
    d0 = done_cnt;
    rst = 1;
    @(negedge clk);
    rst_check("t7_rst");
    rst = 0;
    repeat (4) @(negedge clk);
    chk("t7_no_done", 256'(done_cnt - d0), 256'(0));
    wb = w_q.size(); ab = aw_q.size();
    go(10'h020, 12'd3, 4'hC);
    wait_done("t7b", e, fs);
    chk("t7b_err", 256'(e), 256'(0));
    chk("t7b_frag", 256'(fs), 256'(1));
    check_stream("t7b", wb, ab, 10'h020, 3, 4'hC, 1, 4'h1);

`ifdef PCIE_MSG_TX_BAD_VER_INJ_EN
    wb = w_q.size(); ab = aw_q.size();
    inj = 1;
    go(10'h080, 12'd20, 4'h2);
    inj = 0;
    wait_done("t8", e, fs);
    check_stream("t8", wb, ab, 10'h080, 20, 4'h2, 3, 4'hE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcie_msg_transmitter.md
Name: pcie_msg_transmitter

Overview:
- AXI4 write master that reads a stored message out of the 256-bit message SRAM and splits it into fragments.
- Each fragment is sent as one AXI INCR write burst: a 128-bit message header beat followed by payload beats.
- It is the transmit-side counterpart of pcie_msg_receiver, and its fragments are directly consumable by that receiver.
- Sits between the message SRAM read port and the AXI write channel toward the PCIe message handler.

Parameters:
- MAX_FRAG_BEATS, 8, maximum payload beats per fragment; legal range 1..254.
- HDR_VERSION, 4'h1, value placed in header version field.
- DEST_ADDR, 64'h0, AWADDR used for every fragment.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to send a message; sampled only in IDLE
- msg_sram_addr  in  10  SRAM address of the first payload beat; sampled on start
- msg_beats  in  12  total payload beats; sampled on start
- msg_tag  in  4  message tag; sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at message end
- err  out  1  valid with done; 1 = aborted or rejected
- frag_sent  out  8  fragments completed with OKAY in the current/last message
- axi_awaddr  out  64  = DEST_ADDR
- axi_awlen  out  8  = fragment payload beats (header + payload - 1)
- axi_awsize  out  3  constant 3'd5
- axi_awburst  out  2  constant 2'b01
- axi_awvalid  out  1
- axi_awready  in  1
- axi_wdata  out  256
- axi_wstrb  out  32  constant all ones
- axi_wlast  out  1
- axi_wvalid  out  1
- axi_wready  in  1
- axi_bresp  in  2
- axi_bvalid  in  1
- axi_bready  out  1
- sram_ren  out  1
- sram_raddr  out  10
- sram_rdata  in  256  valid one cycle after sram_ren

Behaviour:
- Reset values: all outputs 0 except the constant fields (awsize, awburst, wstrb, awaddr). State IDLE, buffer empty.
- Header layout (wdata[127:0]; wdata[255:128] = 0):
  - [3:0] HDR_VERSION
  - [7:4] msg_tag
  - [8] SOM, set on the first fragment
  - [9] EOM, set on the last fragment
  - [11:10] fragment sequence number mod 4, starting at 0
  - [19:12] payload beats in this fragment
  - [31:20] msg_beats
  - [127:32] 0
- Fragmentation:
  - Fragment count = ceil(msg_beats / MAX_FRAG_BEATS).
  - All fragments carry MAX_FRAG_BEATS payload beats except the last, which carries the remainder (or MAX_FRAG_BEATS when the division is exact).
- State machine IDLE -> AW -> HDR -> DATA -> RESP -> (AW | DONE) -> IDLE:
  - IDLE: start with msg_beats != 0 latches the inputs, sets busy, and moves to AW.
  - IDLE: start with msg_beats == 0 pulses done and err the next cycle; no AXI or SRAM activity.
  - AW: awvalid held until awready; the AW fields stay stable while valid.
  - HDR: wvalid = 1 with the header beat. wlast = 1 only if the fragment has 0 payload beats, which cannot occur. The header beat is never gated by SRAM.
  - DATA: payload beats come from a 2-entry data buffer.
    - wvalid = buffer not empty.
    - wlast on the final payload beat.
    - The buffer entry pops on wvalid && wready.
  - RESP: bready = 1.
    - On bvalid with bresp == 2'b00: frag_sent increments, then go to AW for the next fragment or to DONE.
    - bresp != 0: go to DONE with err = 1; remaining fragments are not sent.
  - DONE: one-cycle done pulse, busy drops in the same cycle, then IDLE.
- SRAM prefetch:
  - Reads may begin in AW.
  - sram_ren is asserted when remaining fragment reads > 0 and (buffer occupancy + reads in flight) < 2.
  - sram_raddr post-increments per read, wrapping mod 1024.
  - Prefetch never crosses into the next fragment until RESP completes.
- Throughput: one W beat per cycle when wready is held high.
- wvalid never deasserts without a handshake; wdata is stable while stalled.
- start while busy is ignored.
- rst mid-message: everything returns to reset values the next cycle, with no done pulse.

Optional Feature:
- Macro: PCIE_MSG_TX_BAD_VER_INJ_EN.
- Defined: adds input port inj_bad_ver (1 bit).
  - If inj_bad_ver is high when start is accepted, every header of that message carries version HDR_VERSION ^ 4'hF.
  - Used to exercise the receiver's bad-header-version counter.
- Undefined: the port does not exist and the version is always HDR_VERSION.

Test Plan:
- msg_beats=3, MAX=8, addr=10'h010, tag=4'hA, wready/awready/bvalid always ready:
  - Expect 1 burst, awlen=3.
  - Header [31:0] = 32'h0030_33A1.
  - Payload = SRAM[0x010..0x012], wlast on beat 4.
  - done with err=0, frag_sent=1.
- msg_beats=20, MAX=8:
  - Expect 3 bursts with awlen 8, 8, 4.
  - SOM/EOM flags 1/0, 0/0, 0/1; seq 0, 1, 2.
  - frag_sent=3, err=0.
- Same message with wready toggling 1-0-1-0:
  - Identical data order to the unstalled case.
  - wdata stable while stalled; no beat duplicated or skipped.
- Second B response returns bresp=2'b10:
  - No third AW.
  - done with err=1, frag_sent=1.
- msg_beats=0 -> done and err pulse two cycles after start; awvalid and sram_ren never asserted.
- msg_sram_addr=10'h3FE, msg_beats=4 -> reads 3FE, 3FF, 000, 001.
- rst asserted during DATA:
  - The next cycle has all outputs at reset values.
  - A new start completes normally.
- With PCIE_MSG_TX_BAD_VER_INJ_EN and inj_bad_ver=1 -> header[3:0] = 4'hE in every fragment.
